secuenciador_suma_multibyte: RTL

Multi-byte add/subtract sequencer that sits directly in front of the 8-bit ripple-carry adder. It latches two NUM_BYTES-wide operands and feeds the adder one byte per cycle, LSB first, chaining the carry. It captures each byte of sum into a result register and reports the final carry, overflow and zero flags with a one-cycle `listo` pulse. The adder stays a separate instance; the parent wires this block's adder-side ports to it.

---
 rtl/secuenciador_pkg.sv | 17 +
 rtl/secuenciador_suma_multibyte.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/secuenciador_pkg.sv
// Shared types and helpers for the multi-byte add/subtract sequencer.
package secuenciador_pkg;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    SUMANDO = 2'd1,
    FIN     = 2'd2
  } estado_t;

  localparam int ANCHO_BYTE = 8;

  // Width of the byte index register; at least one bit even for tiny widths.
  function automatic int ancho_indice(input int num_bytes);
    return (num_bytes > 1) ? $clog2(num_bytes) : 1;
  endfunction

endpackage

// File: rtl/secuenciador_suma_multibyte.sv
// Multi-byte add/subtract sequencer driving an external 8-bit ripple adder.
// Operands are latched on an accepted start and fed to the adder one byte
// per cycle, LSB first, with the carry chained through a register.
// Optional feature macro: SECUENCIADOR_RESTA_EN enables subtraction
// (B inverted, carry-in of byte 0 = resta). Without it `resta` is ignored.
//
// Handshake: `inicio` is a single-cycle request sampled on the rising edge;
// it is taken in REPOSO, and also on the closing edge of FIN so operations
// can run back to back every NUM_BYTES+1 cycles. While SUMANDO it is
// dropped with no queueing. `listo` pulses for the single FIN cycle, during
// which resultado and the flags are valid; they then hold until the next
// accepted start.
module secuenciador_suma_multibyte
  import secuenciador_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                            reloj,
  input  logic                            reinicio,
  input  logic                            inicio,
  input  logic                            resta,
  input  logic [ANCHO_BYTE*NUM_BYTES-1:0] operando_a,
  input  logic [ANCHO_BYTE*NUM_BYTES-1:0] operando_b,
  output logic [ANCHO_BYTE-1:0]           byte_a_sumador,
  output logic [ANCHO_BYTE-1:0]           byte_b_sumador,
  output logic                            acarreo_al_sumador,
  input  logic [ANCHO_BYTE-1:0]           suma_del_sumador,
  input  logic                            acarreo_del_sumador,
  output logic [ANCHO_BYTE*NUM_BYTES-1:0] resultado,
  output logic                            acarreo_final,
  output logic                            desbordamiento,
  output logic                            cero,
  output logic                            ocupado,
  output logic                            listo,
  output logic [1:0]                      estado_depuracion
);

  localparam int W  = ANCHO_BYTE * NUM_BYTES;
  localparam int IW = ancho_indice(NUM_BYTES);
  localparam logic [IW-1:0] ULTIMO = IW'(NUM_BYTES - 1);

  estado_t                 estado_q, estado_d;
  logic [IW-1:0]           indice_q, indice_d;
  logic [W-1:0]            a_q, a_d;
  logic [W-1:0]            b_q, b_d;
  logic                    acarreo_q, acarreo_d;
  logic [W-1:0]            resultado_q, resultado_d;
  logic                    acarreo_final_q, acarreo_final_d;
  logic                    desbordamiento_q, desbordamiento_d;

  logic                    aceptar;
  logic [ANCHO_BYTE-1:0]   byte_a_sel;
  logic [ANCHO_BYTE-1:0]   byte_b_sel;
  logic [ANCHO_BYTE-1:0]   b_presentado;
  logic                    acarreo_inicial;

  // A start is taken whenever the sequencer is not mid-operation.
  assign aceptar = inicio && (estado_q != SUMANDO);

`ifdef SECUENCIADOR_RESTA_EN
  logic resta_q;

  // Operation mode, captured together with the operands.
  always_ff @(posedge reloj) begin
    if (reinicio) begin
      resta_q <= 1'b0;
    end else if (aceptar) begin
      resta_q <= resta;
    end
  end

  assign b_presentado    = byte_b_sel ^ {ANCHO_BYTE{resta_q}};
  assign acarreo_inicial = resta_q;
`else
  logic unused_resta;

  assign unused_resta    = resta;
  assign b_presentado    = byte_b_sel;
  assign acarreo_inicial = 1'b0;
`endif

  // Select the operand bytes addressed by the current index.
  always_comb begin
    byte_a_sel = '0;
    byte_b_sel = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (indice_q == IW'(k)) begin
        byte_a_sel = a_q[k*ANCHO_BYTE +: ANCHO_BYTE];
        byte_b_sel = b_q[k*ANCHO_BYTE +: ANCHO_BYTE];
      end
    end
  end

  // Next-state and adder-side outputs of the byte sequencer.
  always_comb begin
    estado_d           = estado_q;
    indice_d           = indice_q;
    a_d                = a_q;
    b_d                = b_q;
    acarreo_d          = acarreo_q;
    resultado_d        = resultado_q;
    acarreo_final_d    = acarreo_final_q;
    desbordamiento_d   = desbordamiento_q;
    byte_a_sumador     = '0;
    byte_b_sumador     = '0;
    acarreo_al_sumador = 1'b0;

    case (estado_q)
      REPOSO, FIN: begin
        if (aceptar) begin
          estado_d    = SUMANDO;
          a_d         = operando_a;
          b_d         = operando_b;
          indice_d    = '0;
          acarreo_d   = 1'b0;
          resultado_d = '0;
        end else begin
          estado_d = REPOSO;
        end
      end
      SUMANDO: begin
        byte_a_sumador     = byte_a_sel;
        byte_b_sumador     = b_presentado;
        acarreo_al_sumador = (indice_q == '0) ? acarreo_inicial : acarreo_q;
        for (int k = 0; k < NUM_BYTES; k++) begin
          if (indice_q == IW'(k)) begin
            resultado_d[k*ANCHO_BYTE +: ANCHO_BYTE] = suma_del_sumador;
          end
        end
        acarreo_d = acarreo_del_sumador;
        indice_d  = indice_q + 1'b1;
        if (indice_q == ULTIMO) begin
          acarreo_final_d  = acarreo_del_sumador;
          // Signed overflow: same-sign operands giving a different-sign sum.
          desbordamiento_d = (byte_a_sel[ANCHO_BYTE-1] == b_presentado[ANCHO_BYTE-1]) &&
                             (suma_del_sumador[ANCHO_BYTE-1] != byte_a_sel[ANCHO_BYTE-1]);
          estado_d         = FIN;
        end
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge reloj) begin
    if (reinicio) begin
      estado_q         <= REPOSO;
      indice_q         <= '0;
      a_q              <= '0;
      b_q              <= '0;
      acarreo_q        <= 1'b0;
      resultado_q      <= '0;
      acarreo_final_q  <= 1'b0;
      desbordamiento_q <= 1'b0;
    end else begin
      estado_q         <= estado_d;
      indice_q         <= indice_d;
      a_q              <= a_d;
      b_q              <= b_d;
      acarreo_q        <= acarreo_d;
      resultado_q      <= resultado_d;
      acarreo_final_q  <= acarreo_final_d;
      desbordamiento_q <= desbordamiento_d;
    end
  end

  assign resultado         = resultado_q;
  assign acarreo_final     = acarreo_final_q;
  assign desbordamiento    = desbordamiento_q;
  assign cero              = (resultado_q == '0);
  assign ocupado           = (estado_q != REPOSO);
  assign listo             = (estado_q == FIN);
  assign estado_depuracion = estado_q;

endmodule
